// File: rtl/cpu_pkg.sv
// Shared definitions for the hardwired control sequencer.
// Holds the state encoding, the opcode constants and the opcode-to-ALU-select map.
package cpu_pkg;

  typedef enum logic [3:0] {
    ST_RESET = 4'b0000,
    ST_T0    = 4'b0111,
    ST_T1    = 4'b1000,
    ST_T2    = 4'b1001,
    ST_T3    = 4'b1010,
    ST_T4    = 4'b1011,
    ST_T5    = 4'b1100,
    ST_HALT  = 4'b1101
  } state_t;

  localparam logic [4:0] OPC_ADD  = 5'b00011;
  localparam logic [4:0] OPC_SUB  = 5'b00100;
  localparam logic [4:0] OPC_AND  = 5'b00101;
  localparam logic [4:0] OPC_OR   = 5'b00110;
  localparam logic [4:0] OPC_SHR  = 5'b00111;
  localparam logic [4:0] OPC_SHRA = 5'b01000;
  localparam logic [4:0] OPC_SHL  = 5'b01001;
  localparam logic [4:0] OPC_ROR  = 5'b01010;
  localparam logic [4:0] OPC_ROL  = 5'b01011;
  localparam logic [4:0] OPC_HALT = 5'b11011;

  function automatic logic is_alu(input logic [4:0] opc);
    return opc inside {OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_SHR,
                       OPC_SHRA, OPC_SHL, OPC_ROR, OPC_ROL};
  endfunction

  // The ALU's select codes run one ahead of the opcodes from SHRA upward.
  function automatic logic [4:0] alu_map(input logic [4:0] opc);
    case (opc)
      OPC_SHRA: alu_map = 5'b01001;
      OPC_SHL:  alu_map = 5'b01010;
      OPC_ROR:  alu_map = 5'b01011;
      OPC_ROL:  alu_map = 5'b01100;
      default:  alu_map = opc;
    endcase
  endfunction

endpackage

// File: rtl/reg_decode4to16.sv
// 4-to-16 one-hot register-select decoder with enable.
// Produces all zeros when disabled.
module reg_decode4to16 (
  input  logic [3:0]  i_idx,
  input  logic        i_en,
  output logic [15:0] o_onehot
);

  always_comb begin
    // NOTE: assign a default before any conditional write so no latch is inferred.
    o_onehot = '0;
    if (i_en) o_onehot[i_idx] = 1'b1;
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired control sequencer: fetch (T0-T2) and register-register ALU execute (T3-T5).
// The state register is the only storage; every strobe is decoded from it and the IR fields.
module control_unit
  import cpu_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_ir,
  input  logic        i_mem_ready,
  input  logic        i_stop,
  output logic [15:0] o_rin,
  output logic [15:0] o_rout,
  output logic        o_pc_out,
  output logic        o_pc_in,
  output logic        o_inc_pc,
  output logic        o_mar_in,
  output logic        o_mdr_in,
  output logic        o_mdr_out,
  output logic        o_ir_in,
  output logic        o_yin,
  output logic        o_zlow_in,
  output logic        o_zlow_out,
  output logic        o_read,
  output logic [4:0]  o_op,
  output logic        o_run
);

  state_t      r_state;
  state_t      w_next;
  logic [4:0]  w_opcode;
  logic [3:0]  w_ra;
  logic [3:0]  w_rb;
  logic [3:0]  w_rc;
  logic [3:0]  w_rout_idx;
  logic        w_rin_en;
  logic        w_rout_en;
  logic        w_unused_ir;

  assign w_opcode    = i_ir[31:27];
  assign w_ra        = i_ir[26:23];
  assign w_rb        = i_ir[22:19];
  assign w_rc        = i_ir[18:15];
  assign w_unused_ir = ^i_ir[14:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    if (!i_rst_n) r_state <= ST_RESET;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_rin_en   = 1'b0;
    w_rout_en  = 1'b0;
    w_rout_idx = w_rb;
    o_pc_out   = 1'b0;
    o_pc_in    = 1'b0;
    o_inc_pc   = 1'b0;
    o_mar_in   = 1'b0;
    o_mdr_in   = 1'b0;
    o_mdr_out  = 1'b0;
    o_ir_in    = 1'b0;
    o_yin      = 1'b0;
    o_zlow_in  = 1'b0;
    o_zlow_out = 1'b0;
    o_read     = 1'b0;
    o_op       = 5'b0;
    o_run      = 1'b0;

    case (r_state)
      ST_RESET: w_next = ST_T0;
      ST_T0: begin
        o_run = 1'b1;
        // A pending stop suppresses the fetch so the PC is left untouched.
        if (i_stop) begin
          w_next = ST_HALT;
        end else begin
          o_pc_out = 1'b1;
          o_mar_in = 1'b1;
          o_inc_pc = 1'b1;
          w_next   = ST_T1;
        end
      end
      ST_T1: begin
        o_run    = 1'b1;
        o_read   = 1'b1;
        o_mdr_in = 1'b1;
        if (i_mem_ready) begin
          o_pc_in = 1'b1;
          w_next  = ST_T2;
        end
      end
      ST_T2: begin
        o_run     = 1'b1;
        o_mdr_out = 1'b1;
        o_ir_in   = 1'b1;
        w_next    = ST_T3;
      end
      ST_T3: begin
        o_run = 1'b1;
        if (is_alu(w_opcode)) begin
          w_rout_en = 1'b1;
          o_yin     = 1'b1;
          w_next    = ST_T4;
        end else if (w_opcode == OPC_HALT) begin
          w_next = ST_HALT;
        end else begin
          w_next = ST_T0;
        end
      end
      ST_T4: begin
        o_run      = 1'b1;
        w_rout_en  = 1'b1;
        w_rout_idx = w_rc;
        o_zlow_in  = 1'b1;
        o_op       = alu_map(w_opcode);
        w_next     = ST_T5;
      end
      ST_T5: begin
        o_run      = 1'b1;
        o_zlow_out = 1'b1;
        w_rin_en   = 1'b1;
        w_next     = ST_T0;
      end
      ST_HALT: w_next = ST_HALT;
      default: w_next = ST_RESET;
    endcase
  end

  reg_decode4to16 u_rin_dec (
    .i_idx    (w_ra),
    .i_en     (w_rin_en),
    .o_onehot (o_rin)
  );

  reg_decode4to16 u_rout_dec (
    .i_idx    (w_rout_idx),
    .i_en     (w_rout_en),
    .o_onehot (o_rout)
  );

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: an instruction-level model expands each
// instruction into its expected per-cycle strobe pattern, replayed against the DUT.
module tb_control_unit;

  typedef struct packed {
    logic [15:0] rin;
    logic [15:0] rout;
    logic pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, ir_in, yin, zlow_in, zlow_out, read;
    logic [4:0]  op;
    logic        run;
  } ctl_t;

  typedef struct packed {
    logic        mem_ready;
    logic        stop;
    logic [31:0] ir;
    ctl_t        exp;
  } cyc_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ir = '0;
  logic        mem_ready = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] rin, rout;
  logic pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, ir_in, yin, zlow_in, zlow_out, read, run;
  logic [4:0]  op;
  ctl_t        act;

  int          checks = 0;
  int          failures = 0;
  cyc_t        q[$];
  logic [31:0] cur_ir = '0;

  always #5 clk = ~clk;

  control_unit dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_ir        (ir),
    .i_mem_ready (mem_ready),
    .i_stop      (stop),
    .o_rin       (rin),
    .o_rout      (rout),
    .o_pc_out    (pc_out),
    .o_pc_in     (pc_in),
    .o_inc_pc    (inc_pc),
    .o_mar_in    (mar_in),
    .o_mdr_in    (mdr_in),
    .o_mdr_out   (mdr_out),
    .o_ir_in     (ir_in),
    .o_yin       (yin),
    .o_zlow_in   (zlow_in),
    .o_zlow_out  (zlow_out),
    .o_read      (read),
    .o_op        (op),
    .o_run       (run)
  );

  assign act = {rin, rout, pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, ir_in,
                yin, zlow_in, zlow_out, read, op, run};

  function automatic string show(input ctl_t c);
    return $sformatf("rin=%h rout=%h pcout=%b pcin=%b incpc=%b marin=%b mdrin=%b mdrout=%b irin=%b yin=%b zin=%b zout=%b read=%b op=%b run=%b",
                     c.rin, c.rout, c.pc_out, c.pc_in, c.inc_pc, c.mar_in, c.mdr_in, c.mdr_out,
                     c.ir_in, c.yin, c.zlow_in, c.zlow_out, c.read, c.op, c.run);
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic ctl_t busy();
    ctl_t c = '0;
    c.run = 1'b1;
    return c;
  endfunction

  // ALU select: same as opcode, except the four codes from SHRA to ROL move up by one.
  function automatic logic [4:0] ref_op(input logic [4:0] opc);
    if (opc >= 5'd8 && opc <= 5'd11) return opc + 5'd1;
    return opc;
  endfunction

  function automatic logic [31:0] rand_ir(input logic [4:0] opc);
    logic [26:0] rest;
    rest = 27'($urandom);
    return {opc, rest};
  endfunction

  function automatic logic [4:0] rand_alu_opc();
    return 5'(3 + $urandom_range(0, 8));
  endfunction

  task automatic push(input logic mr, input logic st, input logic [31:0] irv, input ctl_t e);
    cyc_t c;
    c.mem_ready = mr;
    c.stop      = st;
    c.ir        = irv;
    c.exp       = e;
    q.push_back(c);
  endtask

  // Expand one instruction into the cycles the machine should spend on it.
  // The datapath loads the new IR on the edge leaving T2, so it is driven from T3 on.
  task automatic add_instr(input logic [31:0] nir, input int waits, input logic stop_at_t0);
    ctl_t       e;
    logic [4:0] opc;
    logic       alu;
    opc = nir[31:27];
    alu = (opc >= 5'd3 && opc <= 5'd11);

    e = busy();
    if (!stop_at_t0) begin
      e.pc_out = 1'b1;
      e.mar_in = 1'b1;
      e.inc_pc = 1'b1;
    end
    push(rbit(), stop_at_t0, cur_ir, e);
    if (stop_at_t0) begin
      push(rbit(), rbit(), cur_ir, ctl_t'(0));
      return;
    end

    for (int w = 0; w < waits; w++) begin
      e = busy();
      e.read   = 1'b1;
      e.mdr_in = 1'b1;
      push(1'b0, rbit(), cur_ir, e);
    end
    e = busy();
    e.read   = 1'b1;
    e.mdr_in = 1'b1;
    e.pc_in  = 1'b1;
    push(1'b1, rbit(), cur_ir, e);

    e = busy();
    e.mdr_out = 1'b1;
    e.ir_in   = 1'b1;
    push(rbit(), rbit(), cur_ir, e);
    cur_ir = nir;

    e = busy();
    if (alu) begin
      e.rout = 16'b1 << nir[22:19];
      e.yin  = 1'b1;
    end
    push(rbit(), rbit(), nir, e);
    if (opc == 5'b11011) begin
      push(rbit(), rbit(), nir, ctl_t'(0));
      return;
    end
    if (!alu) return;

    e = busy();
    e.rout    = 16'b1 << nir[18:15];
    e.zlow_in = 1'b1;
    e.op      = ref_op(opc);
    push(rbit(), rbit(), nir, e);

    e = busy();
    e.zlow_out = 1'b1;
    e.rin      = 16'b1 << nir[26:23];
    push(rbit(), rbit(), nir, e);
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled on the falling edge.
  task automatic play(input string name);
    foreach (q[i]) begin
      ir        = q[i].ir;
      mem_ready = q[i].mem_ready;
      stop      = q[i].stop;
      @(negedge clk);
      checks++;
      if (act !== q[i].exp) begin
        failures++;
        $display("FAIL %s cycle %0d: got %s", name, i, show(act));
        $display("     %s cycle %0d: want %s", name, i, show(q[i].exp));
      end
      @(posedge clk);
      #1;
    end
    q.delete();
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    mem_ready = 1'b1;
    stop      = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (act !== ctl_t'(0)) begin
        failures++;
        $display("FAIL reset cycle %0d: got %s want all zero", i, show(act));
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_fetch();
    add_instr({5'b00011, 4'd1, 4'd2, 4'd3, 15'd0}, 0, 1'b0);
    play("fetch");
  endtask

  task automatic test_shra();
    add_instr(32'h409A8000, 0, 1'b0);
    play("shra");
  endtask

  task automatic test_wait_states();
    add_instr(rand_ir(rand_alu_opc()), 3, 1'b0);
    play("wait_states");
  endtask

  task automatic test_nop();
    add_instr(rand_ir(5'b11111), 0, 1'b0);
    add_instr(rand_ir(rand_alu_opc()), 0, 1'b0);
    play("nop");
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      logic [4:0] opc;
      opc = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(12, 26)) : rand_alu_opc();
      add_instr(rand_ir(opc), int'($urandom_range(0, 3)), 1'b0);
    end
    play("random");
  endtask

  task automatic test_reset_mid();
    cyc_t c;
    ctl_t e4;
    add_instr(rand_ir(rand_alu_opc()), 1, 1'b0);
    c  = q.pop_back();
    c  = q.pop_back();
    e4 = c.exp;
    play("reset_mid_pre");
    @(negedge clk);
    checks++;
    if (act !== e4) begin
      failures++;
      $display("FAIL reset_mid T4: got %s want %s", show(act), show(e4));
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (act !== ctl_t'(0)) begin
      failures++;
      $display("FAIL reset_mid async clear: got %s want all zero", show(act));
    end
    @(posedge clk);
    #1;
    test_reset();
    add_instr(rand_ir(rand_alu_opc()), 0, 1'b0);
    play("reset_mid_restart");
  endtask

  task automatic test_stop();
    add_instr({5'b00011, 27'($urandom)}, 0, 1'b0);
    q[q.size() - 1].stop = 1'b1;
    add_instr(rand_ir(rand_alu_opc()), 0, 1'b1);
    for (int i = 0; i < 4; i++) push(rbit(), rbit(), cur_ir, ctl_t'(0));
    play("stop_halt");
  endtask

  task automatic test_halt_opcode();
    test_reset();
    add_instr(rand_ir(5'b11011), 2, 1'b0);
    for (int i = 0; i < 4; i++) push(rbit(), rbit(), cur_ir, ctl_t'(0));
    play("halt_opcode");
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_shra();
    test_wait_states();
    test_nop();
    test_random();
    test_reset_mid();
    test_stop();
    test_halt_opcode();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
